// File: rtl/aes_sbox_pkg.sv
// Shared GF(2^8) arithmetic and AES affine helpers for the S-box pipeline.
// Inversion is x^254 by square-and-multiply, which maps 0 to 0 naturally.
package aes_sbox_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [8:0] GF_POLY   = 9'h11B;
    localparam byte_t      AFF_FWD_C = 8'h63;
    localparam byte_t      AFF_INV_C = 8'h05;

    function automatic byte_t gf_mul8(input byte_t a, input byte_t b);
        byte_t p;
        byte_t t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = t[7] ? ((t << 1) ^ GF_POLY[7:0]) : (t << 1);
        end
        return p;
    endfunction

    function automatic byte_t gf_inv8(input byte_t x);
        byte_t x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul8(x, x);
        x3   = gf_mul8(x2, x);
        x6   = gf_mul8(x3, x3);
        x12  = gf_mul8(x6, x6);
        x15  = gf_mul8(x12, x3);
        x30  = gf_mul8(x15, x15);
        x60  = gf_mul8(x30, x30);
        x120 = gf_mul8(x60, x60);
        x240 = gf_mul8(x120, x120);
        // 240 + 12 + 2 = 254
        return gf_mul8(gf_mul8(x240, x12), x2);
    endfunction

    function automatic byte_t aff_fwd(input byte_t b);
        byte_t y;
        for (int i = 0; i < 8; i++) begin
            y[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
        end
        return y ^ AFF_FWD_C;
    endfunction

    // A^-1(b ^ 0x63) folds to A^-1(b) ^ 0x05.
    function automatic byte_t aff_inv(input byte_t b);
        byte_t y;
        for (int i = 0; i < 8; i++) begin
            y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return y ^ AFF_INV_C;
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane, purely combinational: the pre-half feeds the S1 register,
// the post-half consumes it. Both halves are independent of each other.
module aes_sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic  i_pre_inv,
    input  byte_t i_pre_x,
    output byte_t o_pre_y,
    input  logic  i_post_inv,
    input  byte_t i_post_x,
    output byte_t o_post_y
);

    byte_t w_inv_in;

    assign w_inv_in = i_pre_inv ? aff_inv(i_pre_x) : i_pre_x;
    assign o_pre_y  = gf_inv8(w_inv_in);
    assign o_post_y = i_post_inv ? i_post_x : aff_fwd(i_post_x);

endmodule

// File: rtl/aes_sbox_pipe.sv
// Two-stage NUM_LANES-wide forward/inverse AES S-box with a global stall
// and a saturating count of completed output handshakes.
module aes_sbox_pipe
    import aes_sbox_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [8*NUM_LANES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_inv,
    output logic [8*NUM_LANES-1:0] out_data,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       xfer_cnt
);

    localparam int STAGES = 2;

    logic [NUM_LANES-1:0][7:0] w_pre;
    logic [NUM_LANES-1:0][7:0] w_post;
    logic [NUM_LANES-1:0][7:0] r_s1_data;
    logic [NUM_LANES-1:0][7:0] r_s2_data;
    logic [STAGES:1]           r_vld_pipe;
    logic [STAGES:1]           r_inv_pipe;
    logic [CNT_W-1:0]          r_cnt;
    logic                      w_adv;
    logic                      w_xfer;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            aes_sbox_lane u_lane (
                .i_pre_inv  (in_inv),
                .i_pre_x    (in_data[8*g +: 8]),
                .o_pre_y    (w_pre[g]),
                .i_post_inv (r_inv_pipe[1]),
                .i_post_x   (r_s1_data[g]),
                .o_post_y   (w_post[g])
            );
        end
    endgenerate

    // Whole pipe moves or holds together; bubbles travel like words.
    assign w_adv  = !r_vld_pipe[2] || out_ready;
    assign w_xfer = r_vld_pipe[2] && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_inv_pipe <= '0;
            r_s1_data  <= '0;
            r_s2_data  <= '0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[1], in_valid};
            r_inv_pipe <= {r_inv_pipe[1], in_inv};
            r_s1_data  <= w_pre;
            r_s2_data  <= w_post;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_xfer && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_vld_pipe[2];
    assign out_inv   = r_inv_pipe[2];
    assign out_data  = r_s2_data;
    assign xfer_cnt  = r_cnt;

endmodule
